// File: rtl/vreg_pkg.sv
`default_nettype none
// ==================================================================
// vreg_pkg : shared defaults, serial FSM states and S_dir encodings
// Rev 1.0
// ==================================================================
package vreg_pkg;

  localparam int c_nregs = 8;
  localparam int c_lanes = 16;
  localparam int c_ew    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWRITE = 2'd1,
    SREAD  = 2'd2
  } ser_state_e;

  localparam logic c_dir_write = 1'b0;
  localparam logic c_dir_read  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vreg_serial_ctl.sv
`default_nettype none
// ==================================================================
// vreg_serial_ctl : serial stream FSM, element index and handshakes
// Rev 1.0
// ==================================================================
module vreg_serial_ctl
  import vreg_pkg::*;
#(
  parameter int LANES = c_lanes,
  parameter int EW    = c_ew,
  parameter int AW    = 3,
  parameter int IW    = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          S_start,
  input  logic          S_dir,
  input  logic [AW-1:0] S_addr,
  input  logic          WR_p,
  input  logic          In_valid,
  output logic          In_ready,
  input  logic          Out_ready,
  output logic          Out_valid,
  output logic [EW-1:0] DataOut_s,
  output logic          S_busy,
  output logic          S_done,
  output logic          o_wr_en,
  output logic [AW-1:0] o_addr,
  output logic [IW-1:0] o_idx,
  output logic [AW-1:0] o_rd_addr,
  output logic [IW-1:0] o_rd_idx,
  input  logic [EW-1:0] i_rd_elem
);

  ser_state_e    r_state, w_nxt_state;
  logic [AW-1:0] r_addr, w_nxt_addr;
  logic [IW-1:0] r_idx, w_nxt_idx;
  logic          r_out_valid, w_nxt_valid;
  logic          r_done, w_nxt_done;
  logic [EW-1:0] r_dout_s;
  logic          w_load;
  logic          w_last;

  assign w_last = (r_idx == IW'(LANES - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_dout_s    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_addr      <= w_nxt_addr;
      r_idx       <= w_nxt_idx;
      r_out_valid <= w_nxt_valid;
      r_done      <= w_nxt_done;
      if (w_load) r_dout_s <= i_rd_elem;
    end
  end

  // The read-element address looks ahead: S_addr/0 on entry, idx+1 on each accept.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    w_nxt_idx   = r_idx;
    w_nxt_valid = r_out_valid;
    w_nxt_done  = 1'b0;
    w_load      = 1'b0;
    In_ready    = 1'b0;
    o_wr_en     = 1'b0;
    o_rd_addr   = r_addr;
    o_rd_idx    = r_idx + 1'b1;
    case (r_state)
      IDLE: begin
        o_rd_addr = S_addr;
        o_rd_idx  = '0;
        if (S_start) begin
          w_nxt_addr = S_addr;
          w_nxt_idx  = '0;
          if (S_dir == c_dir_read) begin
            w_nxt_state = SREAD;
            w_nxt_valid = 1'b1;
            w_load      = 1'b1;
          end else begin
            w_nxt_state = SWRITE;
          end
        end
      end
      SWRITE: begin
        In_ready = !WR_p;
        if (In_valid && !WR_p) begin
          o_wr_en = 1'b1;
          if (w_last) begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 1'b1;
          end
        end
      end
      SREAD: begin
        if (r_out_valid && Out_ready) begin
          if (w_last) begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
            w_nxt_valid = 1'b0;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 1'b1;
            w_load    = 1'b1;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign S_busy    = (r_state != IDLE);
  assign S_done    = r_done;
  assign Out_valid = r_out_valid;
  assign DataOut_s = r_dout_s;
  assign o_addr    = r_addr;
  assign o_idx     = r_idx;

endmodule
`default_nettype wire

// File: rtl/vreg_bank.sv
`default_nettype none
// ==================================================================
// vreg_bank : vector register file with dual parallel read, masked
//             parallel write and a serial element stream port
// Rev 1.0
// ==================================================================
module vreg_bank
  import vreg_pkg::*;
#(
  parameter int NREGS = c_nregs,
  parameter int LANES = c_lanes,
  parameter int EW    = c_ew,
  parameter int AW    = $clog2(NREGS),
  parameter int IW    = $clog2(LANES)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [AW-1:0]       Addr,
  input  logic [AW-1:0]       Addr2,
  input  logic                RD_p,
  input  logic                WR_p,
  input  logic [LANES-1:0]    WrMask,
  input  logic [LANES*EW-1:0] DataIn_p,
  output logic [LANES*EW-1:0] DataOut_p,
  output logic [LANES*EW-1:0] DataOut2_p,
  input  logic                S_start,
  input  logic                S_dir,
  input  logic [AW-1:0]       S_addr,
  input  logic [EW-1:0]       DataIn_s,
  input  logic                In_valid,
  output logic                In_ready,
  output logic [EW-1:0]       DataOut_s,
  output logic                Out_valid,
  input  logic                Out_ready,
  output logic                S_busy,
  output logic                S_done
);

  logic [EW-1:0] r_mem [NREGS][LANES];
  logic [EW-1:0] w_din_lane [LANES];
  logic          w_ser_we;
  logic [AW-1:0] w_ser_addr;
  logic [IW-1:0] w_ser_idx;
  logic [AW-1:0] w_rd_addr;
  logic [IW-1:0] w_rd_idx;
  logic [EW-1:0] w_rd_elem;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_din_lane[g] = DataIn_p[g*EW +: EW];
  end

  assign w_rd_elem = r_mem[w_rd_addr][w_rd_idx];

  // Non-blocking updates give read-before-write for every port in the same cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++)
          r_mem[r][l] <= '0;
      DataOut_p  <= '0;
      DataOut2_p <= '0;
    end else begin
      if (RD_p) begin
        for (int l = 0; l < LANES; l++) begin
          DataOut_p[l*EW +: EW]  <= r_mem[Addr][l];
          DataOut2_p[l*EW +: EW] <= r_mem[Addr2][l];
        end
      end
      if (WR_p) begin
        for (int l = 0; l < LANES; l++)
          if (WrMask[l]) r_mem[Addr][l] <= w_din_lane[l];
      end
      if (w_ser_we) r_mem[w_ser_addr][w_ser_idx] <= DataIn_s;
    end
  end

  vreg_serial_ctl #(
    .LANES (LANES),
    .EW    (EW),
    .AW    (AW),
    .IW    (IW)
  ) u_serial_ctl (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .S_start   (S_start),
    .S_dir     (S_dir),
    .S_addr    (S_addr),
    .WR_p      (WR_p),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Out_ready (Out_ready),
    .Out_valid (Out_valid),
    .DataOut_s (DataOut_s),
    .S_busy    (S_busy),
    .S_done    (S_done),
    .o_wr_en   (w_ser_we),
    .o_addr    (w_ser_addr),
    .o_idx     (w_ser_idx),
    .o_rd_addr (w_rd_addr),
    .o_rd_idx  (w_rd_idx),
    .i_rd_elem (w_rd_elem)
  );

endmodule
`default_nettype wire
